// File: rtl/ring_monitor.sv
// Checks a one-hot ring counter's rotating output. It locks after a run of correct
// advances, then tracks the phase index and revolutions, and flags sequence errors.
module ring_monitor #(
  parameter int WIDTH         = 4,
  parameter int LOCK_CYCLES   = 2,
  parameter int BAD_LIMIT     = 4,
  parameter int RESYNC_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         phase_in,
  output logic                     locked,
  output logic [$clog2(WIDTH)-1:0] cur_index,
  output logic                     err_pulse,
  output logic [CNT_W-1:0]         err_count,
  output logic [CNT_W-1:0]         rev_count,
  output logic                     resync_req
);

  localparam int IDX_W  = $clog2(WIDTH);
  localparam int GOOD_W = $clog2(LOCK_CYCLES + 1);
  localparam int BAD_W  = $clog2(BAD_LIMIT + 1);
  localparam int RS_W   = $clog2(RESYNC_CYCLES + 1);

  typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED, RESYNC} state_t;

  state_t            state, state_d;
  logic [WIDTH-1:0]  prev, prev_d;
  logic [GOOD_W-1:0] good_cnt, good_d;
  logic [BAD_W-1:0]  bad_cnt, bad_d;
  logic [RS_W-1:0]   rs_cnt, rs_d;
  logic              locked_d, errp_d, resync_d;
  logic [IDX_W-1:0]  idx_d;
  logic [CNT_W-1:0]  errc_d, revc_d;

  logic [WIDTH-1:0]  next_p;
  logic              advance, legal, good_hit, bad_hit, rs_hit;

  function automatic logic [IDX_W-1:0] to_index(input logic [WIDTH-1:0] x);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (x[i]) idx = IDX_W'(i);
    return idx;
  endfunction

  // prev always holds a one-hot value here, so matching its rotation implies legality
  assign next_p   = {prev[WIDTH-2:0], prev[WIDTH-1]};
  assign advance  = (phase_in == next_p);
  assign legal    = $onehot(phase_in);
  assign good_hit = (good_cnt + 1'b1) == GOOD_W'(LOCK_CYCLES);
  assign bad_hit  = (bad_cnt + 1'b1) == BAD_W'(BAD_LIMIT);
  assign rs_hit   = (rs_cnt + 1'b1) == RS_W'(RESYNC_CYCLES);

  always_comb begin
    state_d  = state;
    prev_d   = prev;
    good_d   = good_cnt;
    bad_d    = bad_cnt;
    rs_d     = rs_cnt;
    locked_d = locked;
    idx_d    = cur_index;
    errp_d   = 1'b0;
    errc_d   = err_count;
    revc_d   = rev_count;
    resync_d = resync_req;
    case (state)
      SEARCH: begin
        if (legal) begin
          prev_d  = phase_in;
          good_d  = '0;
          state_d = CONFIRM;
        end else begin
          bad_d = bad_cnt + 1'b1;
          if (bad_hit) begin
            state_d  = RESYNC;
            resync_d = 1'b1;
            rs_d     = '0;
          end
        end
      end
      CONFIRM: begin
        if (advance) begin
          prev_d = phase_in;
          good_d = good_cnt + 1'b1;
          if (good_hit) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
            bad_d    = '0;
            idx_d    = to_index(phase_in);
          end
        end else begin
          bad_d = bad_cnt + 1'b1;
          if (bad_hit) begin
            state_d  = RESYNC;
            resync_d = 1'b1;
            rs_d     = '0;
          end else begin
            state_d = SEARCH;
          end
        end
      end
      LOCKED: begin
        if (advance) begin
          prev_d = phase_in;
          idx_d  = to_index(phase_in);
          if (prev[WIDTH-1]) revc_d = rev_count + 1'b1;
        end else begin
          // The offending sample is discarded; acquisition restarts on the next one
          errp_d   = 1'b1;
          if (err_count != '1) errc_d = err_count + 1'b1;
          locked_d = 1'b0;
          idx_d    = '0;
          state_d  = SEARCH;
        end
      end
      RESYNC: begin
        if (rs_hit) begin
          rs_d     = '0;
          bad_d    = '0;
          resync_d = 1'b0;
          state_d  = SEARCH;
        end else begin
          rs_d = rs_cnt + 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEARCH;
      prev       <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      rs_cnt     <= '0;
      locked     <= 1'b0;
      cur_index  <= '0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      rev_count  <= '0;
      resync_req <= 1'b0;
    end else begin
      state      <= state_d;
      prev       <= prev_d;
      good_cnt   <= good_d;
      bad_cnt    <= bad_d;
      rs_cnt     <= rs_d;
      locked     <= locked_d;
      cur_index  <= idx_d;
      err_pulse  <= errp_d;
      err_count  <= errc_d;
      rev_count  <= revc_d;
      resync_req <= resync_d;
    end
  end

endmodule

// File: doc/ring_monitor.md
Name: ring_monitor

Overview:
- Downstream checker for the one-hot ring counter: samples the counter's `out` bus every clock and verifies the one-hot pattern and the rotation sequence.
- Acquires lock after a programmable number of correct advances.
- While locked, reports the current phase index and counts full revolutions.
- Flags sequence errors with a pulse and a saturating error count.
- Requests a counter re-reset when it cannot acquire lock.

Parameters:
- WIDTH, 4, ring width in bits; must be ≥ 2.
- LOCK_CYCLES, 2, consecutive correct advances required to enter LOCKED; must be ≥ 1.
- BAD_LIMIT, 4, consecutive failed acquisition samples that trigger RESYNC; must be ≥ 1.
- RESYNC_CYCLES, 2, cycles `resync_req` is held high; must be ≥ 1.
- CNT_W, 8, width of `err_count` and `rev_count`.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- phase_in  input  WIDTH  ring counter output (downstream of `out`).
- locked  output  1  high while in LOCKED.
- cur_index  output  $clog2(WIDTH)  index of the set bit of the last accepted phase while locked; 0 otherwise.
- err_pulse  output  1  one-cycle pulse on a sequence error in LOCKED.
- err_count  output  CNT_W  saturating count of `err_pulse` events.
- rev_count  output  CNT_W  wrapping count of completed revolutions while locked.
- resync_req  output  1  request to pulse the ring counter's `rst`.

Behaviour:
- Reset is asynchronous: `rst` high immediately forces all outputs and internal registers to 0 and the state to SEARCH, with no clock needed.
- All outputs are registered and updated on the same edge that samples `phase_in`; response latency is one edge.
- legal(x): exactly one bit of x is set.
- next(p): rotate-left by one, {p[WIDTH-2:0], p[WIDTH-1]}, so the bit index increments and wraps from WIDTH-1 to 0.
- Internal registers: `prev` (WIDTH bits), `good_cnt`, `bad_cnt`, `rs_cnt`.
- SEARCH:
  - If legal(phase_in): `prev <= phase_in`, `good_cnt <= 0`, go to CONFIRM.
  - Else: `bad_cnt++`; if `bad_cnt+1 == BAD_LIMIT`, go to RESYNC.
- CONFIRM:
  - If `phase_in == next(prev)`: `prev <= phase_in`, `good_cnt++`; if `good_cnt+1 == LOCK_CYCLES`, go to LOCKED, `locked <= 1`, `bad_cnt <= 0`.
  - Else: `bad_cnt++`, go to SEARCH, or to RESYNC if `bad_cnt+1 == BAD_LIMIT`. No `err_pulse` is produced.
- LOCKED:
  - If `phase_in == next(prev)`: `prev <= phase_in`, update `cur_index`. If `prev[WIDTH-1]` is set (a wrap), `rev_count++`, wrapping modulo 2^CNT_W.
  - Else: `err_pulse <= 1` for one cycle, `err_count++` saturating at all-ones, `locked <= 0`, `cur_index <= 0`, go to SEARCH. The failing sample is not used for acquisition.
- RESYNC:
  - `resync_req` is high for exactly RESYNC_CYCLES cycles, starting the edge after entry is decided; `phase_in` is ignored.
  - Then `bad_cnt <= 0`, `resync_req <= 0`, go to SEARCH.
- `err_count` and `rev_count` clear only on `rst`. They hold their values across loss of lock and across RESYNC.
- A `phase_in` that is stuck (equal to `prev`) counts as a mismatch.
- An all-zeros or multi-hot `phase_in` counts as illegal, or as a mismatch when locked.

Test Plan (WIDTH=4, LOCK_CYCLES=2, BAD_LIMIT=4, RESYNC_CYCLES=2, CNT_W=2):
- Clean rotation: release `rst`, drive 0001, 0010, 0100, 1000, 0001 on edges 1–5.
  - `locked` = 1 after edge 3, with `cur_index` = 2.
  - `cur_index` = 3 after edge 4.
  - After edge 5: `cur_index` = 0 and `rev_count` = 1.
  - `err_pulse` stays 0 throughout.
- Locked error: while locked at 0010, drive 0110.
  - After that edge: `err_pulse` = 1 for exactly one cycle, `err_count` = 1, `locked` = 0, `cur_index` = 0.
  - A following clean sequence relocks two edges after re-acquisition.
- Stuck zero: drive 0000 from reset.
  - After edge 4, `resync_req` = 1 and stays high for edges 5 and 6 only.
  - Then SEARCH resumes and 0001 is acquired normally.
- Skipped phase in CONFIRM: drive 0001 then 0100.
  - Returns to SEARCH with no `err_pulse`.
  - `bad_cnt` advances; repeating the pattern four times raises `resync_req`.
- Saturation: force 5 locked errors, relocking in between.
  - `err_count` reads 1, 2, 3, 3, 3.
  - `rev_count` keeps its value across each error.
- Async reset mid-LOCKED: assert `rst` between clock edges.
  - All outputs go to 0 before the next edge.
  - After release, the clean sequence relocks as in scenario 1.
